// File: rtl/lcd_ctrl_pkg.sv
// Shared constants, command codes and FSM states for the LCD controller.
package lcd_ctrl_pkg;

    localparam int IMG_W   = 6;
    localparam int WIN_W   = 3;
    localparam int DW      = 8;
    localparam int NPIX    = IMG_W * IMG_W;
    localparam int NWIN    = WIN_W * WIN_W;
    localparam int ORG_MAX = IMG_W - WIN_W;
    localparam int ORG_RST = 2;

    localparam logic [2:0] CMD_REFLASH  = 3'd0;
    localparam logic [2:0] CMD_LOAD     = 3'd1;
    localparam logic [2:0] CMD_SHIFT_R  = 3'd2;
    localparam logic [2:0] CMD_SHIFT_L  = 3'd3;
    localparam logic [2:0] CMD_SHIFT_UP = 3'd4;
    localparam logic [2:0] CMD_SHIFT_DN = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Image index of the k-th window pixel (raster order, columns fastest).
    function automatic logic [5:0] win_idx(input logic [1:0] row, input logic [1:0] col,
                                           input logic [3:0] k);
        int r, c;
        r = int'(row) + int'(k) / WIN_W;
        c = int'(col) + int'(k) % WIN_W;
        return 6'(r * IMG_W + c);
    endfunction

endpackage

// File: rtl/lcd_img_buf.sv
// 36-entry pixel register file: one synchronous write port, one combinational read port.
module lcd_img_buf
    import lcd_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [5:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [5:0]    raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [NPIX];

    // Pixel storage; reset clears the whole image so pre-LOAD windows read zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPIX; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_ctrl_core.sv
// LCD controller core: command FSM, window origin, load/output counters.
module lcd_ctrl_core
    import lcd_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    state_t        state, nxt;
    logic [5:0]    load_cnt;
    logic [3:0]    out_cnt;
    logic [1:0]    org_r, org_c;
    logic [DW-1:0] rd_data;
    logic          accept, load_done, out_done;

    // Busy covers the whole command, including the final output cycle after the FSM returns to IDLE.
    assign busy      = (state != ST_IDLE) || output_valid;
    assign accept    = cmd_valid && !busy;
    assign load_done = (state == ST_LOAD) && (load_cnt == 6'(NPIX - 1));
    assign out_done  = (state == ST_OUT)  && (out_cnt == 4'(NWIN - 1));

    lcd_img_buf u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (state == ST_LOAD),
        .waddr (load_cnt),
        .wdata (datain),
        .raddr (win_idx(org_r, org_c, out_cnt)),
        .rdata (rd_data)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= nxt;
    end

    // Next-state: LOAD streams 36 bytes, then OUT emits the 9 window pixels.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (accept) nxt = (cmd == CMD_LOAD) ? ST_LOAD : ST_OUT;
            ST_LOAD: if (load_done) nxt = ST_OUT;
            ST_OUT:  if (out_done) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // Counters, origin and registered pixel output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt     <= '0;
            out_cnt      <= '0;
            org_r        <= 2'(ORG_RST);
            org_c        <= 2'(ORG_RST);
            dataout      <= '0;
            output_valid <= 1'b0;
        end else begin
            output_valid <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    load_cnt <= '0;
                    out_cnt  <= '0;
                    case (cmd)
                        CMD_LOAD: begin
                            org_r <= 2'(ORG_RST);
                            org_c <= 2'(ORG_RST);
                        end
                        CMD_SHIFT_R:  if (org_c != 2'(ORG_MAX)) org_c <= org_c + 2'd1;
                        CMD_SHIFT_L:  if (org_c != 2'd0)        org_c <= org_c - 2'd1;
                        CMD_SHIFT_UP: if (org_r != 2'd0)        org_r <= org_r - 2'd1;
                        CMD_SHIFT_DN: if (org_r != 2'(ORG_MAX)) org_r <= org_r + 2'd1;
                        default: ;
                    endcase
                end
                ST_LOAD: begin
                    load_cnt <= load_cnt + 6'd1;
                    // Window at the reset origin never touches the last byte, so the
                    // first pixel can be emitted on the same edge that writes byte 36.
                    if (load_done) begin
                        output_valid <= 1'b1;
                        dataout      <= rd_data;
                        out_cnt      <= 4'd1;
                    end
                end
                ST_OUT: begin
                    output_valid <= 1'b1;
                    dataout      <= rd_data;
                    out_cnt      <= out_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_core.sv
// Scoreboard bench for lcd_ctrl_core: a plain image/origin model predicts every window burst.
module tb_lcd_ctrl_core;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] datain;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [7:0] dataout;
    logic       output_valid;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    int         exp_busy_q[$];
    int         busy_run = 0;
    int         ov_run   = 0;

    // Reference model state.
    int         img[36];
    int         mr, mc;
    logic [7:0] load_buf[36];

    lcd_ctrl_core dut (
        .clk          (clk),
        .reset        (reset),
        .datain       (datain),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (img[i]) img[i] = 0;
        mr = 2;
        mc = 2;
    endtask

    // Apply a command to the model and queue its expected burst and busy length.
    task automatic model_cmd(input int c);
        case (c)
            1: begin
                foreach (img[i]) img[i] = int'(load_buf[i]);
                mr = 2; mc = 2;
            end
            2: if (mc < 3) mc++;
            3: if (mc > 0) mc--;
            4: if (mr > 0) mr--;
            5: if (mr < 3) mr++;
            default: ;
        endcase
        for (int r = 0; r < 3; r++)
            for (int cc = 0; cc < 3; cc++)
                exp_q.push_back(8'(img[(mr + r) * 6 + mc + cc]));
        exp_busy_q.push_back(c == 1 ? 45 : 10);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) begin
            n_chk++; n_fail++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", k);
        end
    endtask

    // Issue one command; optionally spray ignored cmd_valid pulses while busy,
    // or abort a LOAD by asserting reset before byte abort_at.
    task automatic send(input int c, input bit noise, input int abort_at);
        int k;
        wait_idle();
        cmd = 3'(c); cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model_cmd(c);
        if (c == 1) begin
            for (int i = 0; i < 36; i++) begin
                if (i == abort_at) begin
                    reset = 1'b0;
                    cmd_valid = 1'b0;
                    #1;
                    chk("abort_busy", int'(busy), 0);
                    chk("abort_ov", int'(output_valid), 0);
                    chk("abort_dataout", int'(dataout), 0);
                    exp_q.delete();
                    exp_busy_q.delete();
                    model_reset();
                    @(posedge clk); #1;
                    reset = 1'b1;
                    return;
                end
                datain = load_buf[i];
                if (noise) begin
                    cmd_valid = 1'(($urandom % 2));
                    cmd = 3'($urandom);
                end
                @(posedge clk); #1;
            end
            datain = 8'($urandom);
        end
        if (noise) begin
            k = 0;
            while (busy && k < 200) begin
                cmd_valid = 1'(($urandom % 2));
                cmd = 3'($urandom);
                @(posedge clk); #1;
                k++;
            end
            cmd_valid = 1'b0;
        end
    endtask

    // Monitor: compares each output pixel, burst length and busy length against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            busy_run = 0;
            ov_run   = 0;
        end else begin
            if (output_valid) begin
                ov_run++;
                chk("ov_within_busy", int'(busy), 1);
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_out: got %0h with no expected pixel", dataout);
                end else begin
                    chk("pixel", int'(dataout), int'(exp_q.pop_front()));
                end
            end else if (ov_run != 0) begin
                chk("burst_len", ov_run, 9);
                ov_run = 0;
            end
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                if (exp_busy_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_busy: got %0d cycles with none expected", busy_run);
                end else begin
                    chk("busy_len", busy_run, exp_busy_q.pop_front());
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        reset = 1'b0; cmd = '0; cmd_valid = 1'b0; datain = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ov", int'(output_valid), 0);
        chk("rst_dataout", int'(dataout), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset image reads zero.
        send(0, 0, -1);

        // Directed image 0x00..0x23 and the window walks from the spec examples.
        foreach (load_buf[i]) load_buf[i] = 8'(i);
        send(1, 0, -1);
        send(2, 0, -1);
        send(2, 0, -1);
        send(1, 0, -1);
        send(4, 0, -1);
        send(4, 0, -1);
        send(4, 0, -1);
        send(1, 0, -1);
        send(3, 0, -1);
        send(3, 0, -1);
        send(5, 0, -1);
        send(0, 0, -1);
        send(7, 0, -1);
        send(6, 0, -1);
        send(5, 0, -1);

        // Ignored cmd_valid pulses while busy.
        send(2, 1, -1);
        send(1, 1, -1);
        send(4, 1, -1);

        // Randomized commands and images.
        for (int n = 0; n < 30; n++) begin
            int c;
            c = int'($urandom % 8);
            if (c == 1) foreach (load_buf[i]) load_buf[i] = 8'($urandom);
            send(c, 1'($urandom % 2), -1);
        end

        // Reset during LOAD byte 20, then REFLASH must give nine zeros.
        foreach (load_buf[i]) load_buf[i] = 8'($urandom | 1);
        send(1, 0, 20);
        send(0, 0, -1);

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_empty", exp_q.size(), 0);
        chk("busy_q_empty", exp_busy_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
